// File: rtl/tc_pkg.sv
// Shared types for the line-fill RAM: fill FSM state encoding and byte width.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package tc_pkg;

  localparam int BYTE_W = 8;

  // Line-fill controller states
  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_t;

endpackage

// File: rtl/tc_ram_core.sv
// Byte-enable synchronous storage array, one write port and one read port, no reset.
// Latency: read data registered, valid the cycle after rd_en; returns pre-write contents on collision.
// Backpressure: none, every enabled access is performed in its cycle.
module tc_ram_core
  import tc_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 512,
  localparam int AW    = $clog2(DEPTH),
  localparam int NB    = DATA_W / BYTE_W
) (
  input  logic              core_clock_i,
  input  logic [NB-1:0]     wr_be,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Byte-lane writes; lanes with a clear enable keep their contents
  always_ff @(posedge core_clock_i) begin
    for (int b = 0; b < NB; b++) begin
      if (wr_be[b]) begin
        mem[wr_addr][b*BYTE_W +: BYTE_W] <= wr_data[b*BYTE_W +: BYTE_W];
      end
    end
  end

  // Registered read; output holds between reads
  always_ff @(posedge core_clock_i) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/tc_line_ram.sv
// Line RAM with a byte-enable single-word write port, a cache-line fill port and a write-first read port.
// Latency: read data 1+OUT_REG cycles after rd_valid_i; fill_done_o the cycle after the last beat.
// Backpressure: wr_ready_o low during a fill (writes dropped); fill_ready_o high only while filling.
module tc_line_ram
  import tc_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 512,
  parameter int LINE_BEATS = 4,
  parameter int OUT_REG    = 0,
  localparam int AW        = $clog2(DEPTH),
  localparam int BW        = $clog2(LINE_BEATS),
  localparam int NB        = DATA_W / BYTE_W
) (
  input  logic              core_clock_i,
  input  logic              core_reset_i,
  input  logic              rd_valid_i,
  input  logic [AW-1:0]     rd_addr_i,
  output logic              rd_valid_o,
  output logic [DATA_W-1:0] rd_data_o,
  input  logic [NB-1:0]     wr_en_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              wr_ready_o,
  input  logic              fill_start_i,
  input  logic [AW-BW-1:0]  fill_line_i,
  input  logic              fill_valid_i,
  input  logic [DATA_W-1:0] fill_data_i,
  output logic              fill_ready_o,
  output logic              fill_busy_o,
  output logic              fill_done_o
);

  // Beat counter keeps at least one bit so single-beat lines still elaborate
  localparam int BCW = (BW > 0) ? BW : 1;

  fill_state_t       state_q;
  logic [BCW-1:0]    beat_q;
  logic [AW-BW-1:0]  fill_line_q;
  logic              wr_ready_q;
  logic              fill_ready_q;
  logic              fill_busy_q;
  logic              fill_done_q;

  logic              fill_we;
  logic [AW-1:0]     fill_addr;
  logic [NB-1:0]     ram_be;
  logic [AW-1:0]     ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] core_rdata;

  logic              rd_v1_q;
  logic [NB-1:0]     fwd_be_q;
  logic [DATA_W-1:0] fwd_data_q;
  logic [DATA_W-1:0] rd_merged;
  logic [DATA_W-1:0] data_s1;
  logic [DATA_W-1:0] hold_q;

  assign fill_we   = fill_ready_q && fill_valid_i;
  assign fill_addr = (AW'(fill_line_q) << BW) | AW'(beat_q);

  // Storage write port: a fill beat owns it in FILL, the single-word port in IDLE
  always_comb begin
    ram_be    = wr_ready_q ? wr_en_i : '0;
    ram_addr  = wr_addr_i;
    ram_wdata = wr_data_i;
    if (fill_we) begin
      ram_be    = '1;
      ram_addr  = fill_addr;
      ram_wdata = fill_data_i;
    end
  end

  tc_ram_core #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_core (
    .core_clock_i (core_clock_i),
    .wr_be        (ram_be),
    .wr_addr      (ram_addr),
    .wr_data      (ram_wdata),
    .rd_en        (rd_valid_i),
    .rd_addr      (rd_addr_i),
    .rd_data      (core_rdata)
  );

  // Fill controller; status outputs are registered alongside the state
  always_ff @(posedge core_clock_i or posedge core_reset_i) begin
    if (core_reset_i) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      fill_line_q  <= '0;
      wr_ready_q   <= 1'b1;
      fill_ready_q <= 1'b0;
      fill_busy_q  <= 1'b0;
      fill_done_q  <= 1'b0;
    end else begin
      fill_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (fill_start_i) begin
            state_q      <= FILL;
            fill_line_q  <= fill_line_i;
            beat_q       <= '0;
            wr_ready_q   <= 1'b0;
            fill_ready_q <= 1'b1;
            fill_busy_q  <= 1'b1;
          end
        end
        FILL: begin
          if (fill_valid_i) begin
            beat_q <= beat_q + BCW'(1);
            if (beat_q == BCW'(LINE_BEATS - 1)) begin
              state_q      <= IDLE;
              wr_ready_q   <= 1'b1;
              fill_ready_q <= 1'b0;
              fill_busy_q  <= 1'b0;
              fill_done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Read valid pipeline and the byte lanes written to the address being read
  always_ff @(posedge core_clock_i or posedge core_reset_i) begin
    if (core_reset_i) begin
      rd_v1_q  <= 1'b0;
      fwd_be_q <= '0;
    end else begin
      rd_v1_q  <= rd_valid_i;
      fwd_be_q <= (rd_valid_i && (ram_addr == rd_addr_i)) ? ram_be : '0;
    end
  end

  // Captured write data for same-cycle collisions; only meaningful where fwd_be_q is set
  always_ff @(posedge core_clock_i) begin
    fwd_data_q <= ram_wdata;
  end

  // Write-first merge: newly written lanes replace the array's pre-write read data
  always_comb begin
    rd_merged = core_rdata;
    for (int b = 0; b < NB; b++) begin
      if (fwd_be_q[b]) begin
        rd_merged[b*BYTE_W +: BYTE_W] = fwd_data_q[b*BYTE_W +: BYTE_W];
      end
    end
    data_s1 = rd_v1_q ? rd_merged : hold_q;
  end

  // Last returned word, so the output holds and reads as zero out of reset
  always_ff @(posedge core_clock_i or posedge core_reset_i) begin
    if (core_reset_i) begin
      hold_q <= '0;
    end else begin
      hold_q <= data_s1;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic              out_v_q;
      logic [DATA_W-1:0] out_d_q;

      // Optional extra output stage for timing
      always_ff @(posedge core_clock_i or posedge core_reset_i) begin
        if (core_reset_i) begin
          out_v_q <= 1'b0;
          out_d_q <= '0;
        end else begin
          out_v_q <= rd_v1_q;
          out_d_q <= data_s1;
        end
      end

      assign rd_valid_o = out_v_q;
      assign rd_data_o  = out_d_q;
    end else begin : g_no_out_reg
      assign rd_valid_o = rd_v1_q;
      assign rd_data_o  = data_s1;
    end
  endgenerate

  assign wr_ready_o   = wr_ready_q;
  assign fill_ready_o = fill_ready_q;
  assign fill_busy_o  = fill_busy_q;
  assign fill_done_o  = fill_done_q;

endmodule

// File: tb/tb_tc_line_ram.sv
// Self-checking bench for tc_line_ram: scoreboard of expected read data and arrival cycle.
// Latency: checks read data arrives exactly 1+OUT_REG cycles after the request.
// Backpressure: checks writes are dropped and wr_ready_o is low while a fill runs.
module tb_tc_line_ram;

  localparam int DATA_W  = 32;
  localparam int DEPTH   = 512;
  localparam int LB      = 4;
  localparam int OUT_REG = 0;
  localparam int AW      = 9;
  localparam int BW      = 2;

  logic              core_clock_i;
  logic              core_reset_i;
  logic              rd_valid_i;
  logic [AW-1:0]     rd_addr_i;
  logic              rd_valid_o;
  logic [DATA_W-1:0] rd_data_o;
  logic [3:0]        wr_en_i;
  logic [AW-1:0]     wr_addr_i;
  logic [DATA_W-1:0] wr_data_i;
  logic              wr_ready_o;
  logic              fill_start_i;
  logic [AW-BW-1:0]  fill_line_i;
  logic              fill_valid_i;
  logic [DATA_W-1:0] fill_data_i;
  logic              fill_ready_o;
  logic              fill_busy_o;
  logic              fill_done_o;

  tc_line_ram #(
    .DATA_W     (DATA_W),
    .DEPTH      (DEPTH),
    .LINE_BEATS (LB),
    .OUT_REG    (OUT_REG)
  ) dut (
    .core_clock_i (core_clock_i),
    .core_reset_i (core_reset_i),
    .rd_valid_i   (rd_valid_i),
    .rd_addr_i    (rd_addr_i),
    .rd_valid_o   (rd_valid_o),
    .rd_data_o    (rd_data_o),
    .wr_en_i      (wr_en_i),
    .wr_addr_i    (wr_addr_i),
    .wr_data_i    (wr_data_i),
    .wr_ready_o   (wr_ready_o),
    .fill_start_i (fill_start_i),
    .fill_line_i  (fill_line_i),
    .fill_valid_i (fill_valid_i),
    .fill_data_i  (fill_data_i),
    .fill_ready_o (fill_ready_o),
    .fill_busy_o  (fill_busy_o),
    .fill_done_o  (fill_done_o)
  );

  initial core_clock_i = 1'b0;
  always #5 core_clock_i = ~core_clock_i;

  typedef struct {
    logic [DATA_W-1:0] dat;
    int                due;
  } exp_t;

  exp_t              sb[$];
  logic [DATA_W-1:0] mdl [DEPTH];
  int                checks   = 0;
  int                failures = 0;
  int                cyc      = 0;
  int                done_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] bmerge(input logic [DATA_W-1:0] old_w,
                                               input logic [DATA_W-1:0] new_w,
                                               input logic [3:0] be);
    logic [DATA_W-1:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    return r;
  endfunction

  always @(posedge core_clock_i) cyc <= cyc + 1;

  // Read monitor: every returned word must match the oldest outstanding expectation
  always @(negedge core_clock_i) begin
    if (fill_done_o) done_cnt++;
    if (!core_reset_i && rd_valid_o) begin
      if (sb.size() == 0) begin
        chk("rd_unexpected_qsize", 64'(sb.size()), 64'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rd_data", 64'(rd_data_o), 64'(e.dat));
        chk("rd_latency", 64'(cyc), 64'(e.due));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  task automatic step();
    @(posedge core_clock_i);
    #1;
  endtask

  task automatic wr(input int a, input logic [DATA_W-1:0] d, input logic [3:0] be);
    wr_en_i   = be;
    wr_addr_i = AW'(a);
    wr_data_i = d;
    mdl[a]    = bmerge(mdl[a], d, be);
    step();
    wr_en_i   = '0;
  endtask

  task automatic push_rd(input int a);
    exp_t e;
    rd_valid_i = 1'b1;
    rd_addr_i  = AW'(a);
    e.dat      = mdl[a];
    e.due      = cyc + 1 + OUT_REG;
    sb.push_back(e);
  endtask

  task automatic rd(input int a);
    push_rd(a);
    step();
    rd_valid_i = 1'b0;
  endtask

  // Drives a fill of nbeats; optional gap with a (dropped) single write, optional start poke
  task automatic run_fill(input int line, input logic [DATA_W-1:0] base, input int nbeats,
                          input int gap_at, input bit poke);
    fill_start_i = 1'b1;
    fill_line_i  = (AW-BW)'(line);
    step();
    fill_start_i = 1'b0;
    chk("fill_busy", 64'(fill_busy_o), 64'd1);
    chk("fill_wr_ready", 64'(wr_ready_o), 64'd0);
    chk("fill_ready", 64'(fill_ready_o), 64'd1);
    for (int i = 0; i < nbeats; i++) begin
      if (i == gap_at) begin
        fill_valid_i = 1'b0;
        wr_en_i      = 4'hF;
        wr_addr_i    = AW'(20);
        wr_data_i    = 32'hFFFF_FFFF;
        step();
        wr_en_i = '0;
        chk("gap_wr_ready", 64'(wr_ready_o), 64'd0);
        chk("gap_busy", 64'(fill_busy_o), 64'd1);
      end
      if (poke && i == 1) begin
        fill_start_i = 1'b1;
        fill_line_i  = (AW-BW)'(5);
      end
      fill_valid_i = 1'b1;
      fill_data_i  = base + DATA_W'(i);
      mdl[line*LB + i] = base + DATA_W'(i);
      step();
      fill_valid_i = 1'b0;
      fill_start_i = 1'b0;
      if (i < LB - 1) chk("beat_wr_ready", 64'(wr_ready_o), 64'd0);
    end
  endtask

  task automatic chk_fill_end(input int d0);
    chk("end_done", 64'(fill_done_o), 64'd1);
    chk("end_busy", 64'(fill_busy_o), 64'd0);
    chk("end_wr_ready", 64'(wr_ready_o), 64'd1);
    step();
    chk("end_done_drop", 64'(fill_done_o), 64'd0);
    chk("done_count", 64'(done_cnt - d0), 64'd1);
  endtask

  initial begin
    int d0;
    core_reset_i = 1'b1;
    rd_valid_i   = 1'b0;
    rd_addr_i    = '0;
    wr_en_i      = '0;
    wr_addr_i    = '0;
    wr_data_i    = '0;
    fill_start_i = 1'b0;
    fill_line_i  = '0;
    fill_valid_i = 1'b0;
    fill_data_i  = '0;
    for (int i = 0; i < DEPTH; i++) mdl[i] = 'x;
    #3;
    chk("rst_rd_valid", 64'(rd_valid_o), 64'd0);
    chk("rst_rd_data", 64'(rd_data_o), 64'd0);
    chk("rst_wr_ready", 64'(wr_ready_o), 64'd1);
    chk("rst_fill_ready", 64'(fill_ready_o), 64'd0);
    chk("rst_fill_busy", 64'(fill_busy_o), 64'd0);
    chk("rst_fill_done", 64'(fill_done_o), 64'd0);
    step();
    core_reset_i = 1'b0;
    step();

    // Full-word write then read back
    wr(5, 32'hDEAD_BEEF, 4'hF);
    rd(5);
    step();

    // Same-cycle read and partial write: write-first merge
    wr(7, 32'h1122_3344, 4'hF);
    wr_en_i   = 4'h3;
    wr_addr_i = AW'(7);
    wr_data_i = 32'hAABB_CCDD;
    mdl[7]    = bmerge(mdl[7], 32'hAABB_CCDD, 4'h3);
    push_rd(7);
    step();
    rd_valid_i = 1'b0;
    wr_en_i    = '0;
    rd(7);

    // Background contents for lines 2, 3 and 5
    for (int a = 8; a < 16; a++) wr(a, 32'h5500_0000 + DATA_W'(a), 4'hF);
    for (int a = 20; a < 24; a++) wr(a, 32'h2000_0000 + DATA_W'(a), 4'hF);

    // Fill line 2 with a gap after beat 1 and a dropped write during the gap
    d0 = done_cnt;
    run_fill(2, 32'hA0, LB, 2, 1'b0);
    chk_fill_end(d0);
    for (int a = 8; a < 12; a++) rd(a);
    rd(20);

    // Start pulse during a fill is ignored
    d0 = done_cnt;
    run_fill(3, 32'hB0, LB, -1, 1'b1);
    chk_fill_end(d0);
    repeat (2) step();
    chk("poke_busy_after", 64'(fill_busy_o), 64'd0);
    chk("poke_done_count", 64'(done_cnt - d0), 64'd1);
    for (int a = 12; a < 16; a++) rd(a);
    for (int a = 20; a < 24; a++) rd(a);
    repeat (3) step();

    // Reset after two beats aborts the fill
    d0 = done_cnt;
    run_fill(2, 32'hC0, 2, -1, 1'b0);
    core_reset_i = 1'b1;
    #1;
    chk("abort_busy", 64'(fill_busy_o), 64'd0);
    chk("abort_fill_ready", 64'(fill_ready_o), 64'd0);
    chk("abort_wr_ready", 64'(wr_ready_o), 64'd1);
    chk("abort_rd_data", 64'(rd_data_o), 64'd0);
    step();
    core_reset_i = 1'b0;
    repeat (2) step();
    chk("abort_done_count", 64'(done_cnt - d0), 64'd0);
    for (int a = 8; a < 12; a++) rd(a);

    // Random reads and partial writes over a small window to stress forwarding
    for (int a = 32; a < 40; a++) wr(a, $urandom, 4'hF);
    for (int k = 0; k < 80; k++) begin
      int wa;
      int ra;
      wa = 32 + int'($urandom_range(0, 7));
      ra = 32 + int'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) begin
        wr_en_i   = 4'($urandom_range(0, 15));
        wr_addr_i = AW'(wa);
        wr_data_i = $urandom;
        mdl[wa]   = bmerge(mdl[wa], wr_data_i, wr_en_i);
      end
      if ($urandom_range(0, 1) == 1) push_rd(ra);
      step();
      wr_en_i    = '0;
      rd_valid_i = 1'b0;
    end

    for (int k = 0; k < 20 && sb.size() != 0; k++) step();
    chk("drain_qsize", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
